// File: rtl/vproc_cfg_unit.sv
// Vector configuration / CSR execution unit: vsetvl variants, vtype/vl/vlenb reads and
// vstart/vxsat/vxrm/vcsr read-modify-write, one operation in flight at a time.
module vproc_cfg_unit #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned ELEN   = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ID_W   = 3
) (
  input  logic                        clk_i,
  input  logic                        async_rst_i,
  input  logic                        op_valid_i,
  output logic                        op_ready_o,
  input  logic [ID_W-1:0]             op_id_i,
  input  logic [3:0]                  op_csr_i,
  input  logic [1:0]                  op_vsew_i,
  input  logic [2:0]                  op_lmul_i,
  input  logic [1:0]                  op_agnostic_i,
  input  logic                        op_vlmax_i,
  input  logic                        op_keep_vl_i,
  input  logic [XLEN-1:0]             op_rs1_i,
  input  logic                        vec_idle_i,
  input  logic                        vxsat_set_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [ID_W-1:0]             res_id_o,
  output logic [XLEN-1:0]             res_val_o,
  output logic [XLEN-1:0]             vtype_o,
  output logic [$clog2(VREG_W):0]     vl_o,
  output logic [$clog2(VREG_W)-1:0]   vstart_o,
  output logic [1:0]                  vxrm_o,
  output logic                        vxsat_o
);

  // state | meaning
  // IDLE  | ready for a new operation
  // WAIT  | op latched, waiting for the vector units to drain
  // EXEC  | CSR update and result capture
  // RESP  | result presented until accepted
  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_e;

  localparam int unsigned VL_W      = $clog2(VREG_W) + 1;
  localparam int unsigned VS_W      = $clog2(VREG_W);
  localparam int unsigned ELEN_LOG2 = $clog2(ELEN);

  localparam logic [3:0] OP_VSETVL   = 4'd0;
  localparam logic [3:0] OP_VTYPE_RD = 4'd1;
  localparam logic [3:0] OP_VL_RD    = 4'd2;
  localparam logic [3:0] OP_VLENB_RD = 4'd3;

  state_e state_q, state_d;
  logic   exec_en;

  logic [ID_W-1:0] op_id_q;
  logic [3:0]      op_csr_q;
  logic [1:0]      op_vsew_q;
  logic [2:0]      op_lmul_q;
  logic [1:0]      op_agn_q;
  logic            op_vlmax_q, op_keep_q;
  logic [XLEN-1:0] op_rs1_q;

  logic            vill_q, vill_d, vma_q, vma_d, vta_q, vta_d;
  logic [2:0]      vsew_q, vsew_d, vlmul_q, vlmul_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VS_W-1:0] vstart_q, vstart_d;
  logic [1:0]      vxrm_q, vxrm_d;
  logic            vxsat_q, vxsat_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [XLEN-1:0] res_val_q, res_val_d;

  logic [3:0]      shamt;
  logic [VL_W-1:0] vlmax, vl_new;
  logic            cfg_ill;
  logic [VS_W-1:0] csr_old, csr_new;

  function automatic logic needs_drain(input logic [3:0] op);
    return !(op inside {OP_VTYPE_RD, OP_VL_RD, OP_VLENB_RD});
  endfunction

  // WRITE/SET/CLEAR repeat in groups of three from opcode 4 upward
  function automatic logic [VS_W-1:0] csr_rmw(input logic [VS_W-1:0] old_v,
                                               input logic [VS_W-1:0] wr_v,
                                               input logic [3:0]      op);
    case (op)
      4'd4, 4'd7, 4'd10, 4'd13: return wr_v;
      4'd5, 4'd8, 4'd11, 4'd14: return old_v | wr_v;
      default:                  return old_v & ~wr_v;
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (op_valid_i) state_d = (needs_drain(op_csr_i) && !vec_idle_i) ? WAIT : EXEC;
      WAIT: if (vec_idle_i) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready_o  = (state_q == IDLE);
    res_valid_o = (state_q == RESP);
    exec_en     = (state_q == EXEC);
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      op_id_q    <= '0;
      op_csr_q   <= '0;
      op_vsew_q  <= '0;
      op_lmul_q  <= '0;
      op_agn_q   <= '0;
      op_vlmax_q <= 1'b0;
      op_keep_q  <= 1'b0;
      op_rs1_q   <= '0;
    end else if (op_valid_i && op_ready_o) begin
      op_id_q    <= op_id_i;
      op_csr_q   <= op_csr_i;
      op_vsew_q  <= op_vsew_i;
      op_lmul_q  <= op_lmul_i;
      op_agn_q   <= op_agnostic_i;
      op_vlmax_q <= op_vlmax_i;
      op_keep_q  <= op_keep_vl_i;
      op_rs1_q   <= op_rs1_i;
    end
  end

  // lmul code read as a signed exponent; shamt is only meaningful for legal configurations
  always_comb begin
    shamt   = 4'd3 + {2'b00, op_vsew_q} - {op_lmul_q[2], op_lmul_q};
    vlmax   = VL_W'(VREG_W >> shamt);
    cfg_ill = (op_lmul_q == 3'b100) ||
              ((op_vsew_q == 2'd3) && (ELEN == 32)) ||
              (op_lmul_q[2] && (shamt > 4'(ELEN_LOG2)));
    if (op_vlmax_q)     vl_new = vlmax;
    else if (op_keep_q) vl_new = (vl_q < vlmax) ? vl_q : vlmax;
    else                vl_new = (op_rs1_q < XLEN'(vlmax)) ? op_rs1_q[VL_W-1:0] : vlmax;
  end

  always_comb begin
    unique case (op_csr_q)
      4'd4, 4'd5, 4'd6:    csr_old = vstart_q;
      4'd7, 4'd8, 4'd9:    csr_old = VS_W'(vxsat_q);
      4'd10, 4'd11, 4'd12: csr_old = VS_W'(vxrm_q);
      default:             csr_old = VS_W'({vxrm_q, vxsat_q});
    endcase
    csr_new = csr_rmw(csr_old, op_rs1_q[VS_W-1:0], op_csr_q);
  end

  always_comb begin
    vill_d    = vill_q;
    vma_d     = vma_q;
    vta_d     = vta_q;
    vsew_d    = vsew_q;
    vlmul_d   = vlmul_q;
    vl_d      = vl_q;
    vstart_d  = vstart_q;
    vxrm_d    = vxrm_q;
    vxsat_d   = vxsat_q | vxsat_set_i;
    res_id_d  = res_id_q;
    res_val_d = res_val_q;
    if (exec_en) begin
      res_id_d = op_id_q;
      unique case (op_csr_q)
        OP_VSETVL: begin
          vstart_d = '0;
          if (cfg_ill) begin
            {vill_d, vma_d, vta_d, vsew_d, vlmul_d} = {1'b1, 8'd0};
            vl_d      = '0;
            res_val_d = '0;
          end else begin
            {vill_d, vma_d, vta_d} = {1'b0, op_agn_q};
            vsew_d    = {1'b0, op_vsew_q};
            vlmul_d   = op_lmul_q;
            vl_d      = vl_new;
            res_val_d = XLEN'(vl_new);
          end
        end
        OP_VTYPE_RD: res_val_d = vtype_o;
        OP_VL_RD:    res_val_d = XLEN'(vl_q);
        OP_VLENB_RD: res_val_d = XLEN'(VREG_W / 8);
        4'd4, 4'd5, 4'd6: begin
          res_val_d = XLEN'(csr_old);
          vstart_d  = csr_new;
        end
        // an explicit vxsat write wins over a same-cycle saturation event
        4'd7, 4'd8, 4'd9: begin
          res_val_d = XLEN'(csr_old);
          vxsat_d   = csr_new[0];
        end
        4'd10, 4'd11, 4'd12: begin
          res_val_d = XLEN'(csr_old);
          vxrm_d    = csr_new[1:0];
        end
        default: begin
          res_val_d = XLEN'(csr_old);
          vxsat_d   = csr_new[0];
          vxrm_d    = csr_new[2:1];
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      vill_q    <= 1'b1;
      vma_q     <= 1'b0;
      vta_q     <= 1'b0;
      vsew_q    <= '0;
      vlmul_q   <= '0;
      vl_q      <= '0;
      vstart_q  <= '0;
      vxrm_q    <= '0;
      vxsat_q   <= 1'b0;
      res_id_q  <= '0;
      res_val_q <= '0;
    end else begin
      vill_q    <= vill_d;
      vma_q     <= vma_d;
      vta_q     <= vta_d;
      vsew_q    <= vsew_d;
      vlmul_q   <= vlmul_d;
      vl_q      <= vl_d;
      vstart_q  <= vstart_d;
      vxrm_q    <= vxrm_d;
      vxsat_q   <= vxsat_d;
      res_id_q  <= res_id_d;
      res_val_q <= res_val_d;
    end
  end

  assign vtype_o   = {vill_q, {(XLEN-9){1'b0}}, vma_q, vta_q, vsew_q, vlmul_q};
  assign vl_o      = vl_q;
  assign vstart_o  = vstart_q;
  assign vxrm_o    = vxrm_q;
  assign vxsat_o   = vxsat_q;
  assign res_id_o  = res_id_q;
  assign res_val_o = res_val_q;

endmodule

// File: tb/tb_vproc_cfg_unit.sv
// Scoreboard bench for vproc_cfg_unit: ELEN=32 and ELEN=64 instances share stimulus,
// each with its own reference-model state and expectation queue.
module tb_vproc_cfg_unit;
  localparam int VREG_W = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        op_valid_i, vec_idle_i, vxsat_set_i, res_ready_i, op_vlmax_i, op_keep_vl_i;
  logic [2:0]  op_id_i, op_lmul_i;
  logic [3:0]  op_csr_i;
  logic [1:0]  op_vsew_i, op_agnostic_i;
  logic [31:0] op_rs1_i;

  logic        op_ready_w[2], res_valid_w[2], vxsat_w[2];
  logic [2:0]  res_id_w[2];
  logic [31:0] res_val_w[2], vtype_w[2];
  logic [7:0]  vl_w[2];
  logic [6:0]  vstart_w[2];
  logic [1:0]  vxrm_w[2];

  vproc_cfg_unit #(.VREG_W(VREG_W), .ELEN(32), .XLEN(32), .ID_W(3)) u_dut32 (
    .clk_i(clk), .async_rst_i(rst), .op_valid_i(op_valid_i), .op_ready_o(op_ready_w[0]),
    .op_id_i(op_id_i), .op_csr_i(op_csr_i), .op_vsew_i(op_vsew_i), .op_lmul_i(op_lmul_i),
    .op_agnostic_i(op_agnostic_i), .op_vlmax_i(op_vlmax_i), .op_keep_vl_i(op_keep_vl_i),
    .op_rs1_i(op_rs1_i), .vec_idle_i(vec_idle_i), .vxsat_set_i(vxsat_set_i),
    .res_valid_o(res_valid_w[0]), .res_ready_i(res_ready_i), .res_id_o(res_id_w[0]),
    .res_val_o(res_val_w[0]), .vtype_o(vtype_w[0]), .vl_o(vl_w[0]), .vstart_o(vstart_w[0]),
    .vxrm_o(vxrm_w[0]), .vxsat_o(vxsat_w[0]));

  vproc_cfg_unit #(.VREG_W(VREG_W), .ELEN(64), .XLEN(32), .ID_W(3)) u_dut64 (
    .clk_i(clk), .async_rst_i(rst), .op_valid_i(op_valid_i), .op_ready_o(op_ready_w[1]),
    .op_id_i(op_id_i), .op_csr_i(op_csr_i), .op_vsew_i(op_vsew_i), .op_lmul_i(op_lmul_i),
    .op_agnostic_i(op_agnostic_i), .op_vlmax_i(op_vlmax_i), .op_keep_vl_i(op_keep_vl_i),
    .op_rs1_i(op_rs1_i), .vec_idle_i(vec_idle_i), .vxsat_set_i(vxsat_set_i),
    .res_valid_o(res_valid_w[1]), .res_ready_i(res_ready_i), .res_id_o(res_id_w[1]),
    .res_val_o(res_val_w[1]), .vtype_o(vtype_w[1]), .vl_o(vl_w[1]), .vstart_o(vstart_w[1]),
    .vxrm_o(vxrm_w[1]), .vxsat_o(vxsat_w[1]));

  typedef struct {
    logic [31:0] val, id, vtype, vl, vstart, vxrm, vxsat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_bad = 0;

  // architectural state of the model, per instance
  int m_vill[2], m_vma[2], m_vta[2], m_sew[2], m_lmul[2];
  int m_vl[2], m_vstart[2], m_vxrm[2], m_vxsat[2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s elen%0d: got 0x%0h expected 0x%0h at %0t", name, (k == 1) ? 64 : 32, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] vtype_of(input int k);
    return (32'(m_vill[k]) << 31) | (32'(m_vma[k]) << 7) | (32'(m_vta[k]) << 6) |
           (32'(m_sew[k]) << 3) | 32'(m_lmul[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_vill[k] = 1; m_vma[k] = 0; m_vta[k] = 0; m_sew[k] = 0; m_lmul[k] = 0;
      m_vl[k] = 0; m_vstart[k] = 0; m_vxrm[k] = 0; m_vxsat[k] = 0;
    end
  endtask

  task automatic model_exec(input int k, input int op, input int sew, input int lmul, input int agn,
                            input bit vlm, input bit keep, input logic [31:0] rs1, input logic [2:0] id,
                            input bit early_set, input bit late_set, output exp_t e);
    int elen, sew_bits, den, vlmax, grp, kind;
    longint unsigned r, old_v, new_v, mask;
    bit ill;
    elen = (k == 1) ? 64 : 32;
    r = 64'(rs1);
    if (early_set) m_vxsat[k] = 1;
    e.id = 32'(id);
    e.val = 0;
    if (op == 0) begin
      sew_bits = 8 << sew;
      ill = (lmul == 4) || (sew_bits > elen);
      if (lmul >= 5) begin
        den = 1 << (8 - lmul);
        if (sew_bits * den > elen) ill = 1;
        vlmax = VREG_W / (sew_bits * den);
      end else begin
        vlmax = (VREG_W * (1 << lmul)) / sew_bits;
      end
      m_vstart[k] = 0;
      if (ill) begin
        m_vill[k] = 1; m_vma[k] = 0; m_vta[k] = 0; m_sew[k] = 0; m_lmul[k] = 0; m_vl[k] = 0;
      end else begin
        m_vill[k] = 0; m_vma[k] = agn >> 1; m_vta[k] = agn & 1; m_sew[k] = sew; m_lmul[k] = lmul;
        if (vlm)       m_vl[k] = vlmax;
        else if (keep) m_vl[k] = (m_vl[k] < vlmax) ? m_vl[k] : vlmax;
        else           m_vl[k] = (r < 64'(vlmax)) ? int'(r) : vlmax;
        e.val = 32'(m_vl[k]);
      end
    end else if (op == 1) e.val = vtype_of(k);
    else if (op == 2) e.val = 32'(m_vl[k]);
    else if (op == 3) e.val = VREG_W / 8;
    else begin
      grp = (op - 4) / 3;
      kind = (op - 4) % 3;
      case (grp)
        0: begin old_v = 64'(m_vstart[k]); mask = VREG_W - 1; end
        1: begin old_v = 64'(m_vxsat[k]); mask = 1; end
        2: begin old_v = 64'(m_vxrm[k]); mask = 3; end
        default: begin old_v = 64'(m_vxrm[k] * 2 + m_vxsat[k]); mask = 7; end
      endcase
      if (kind == 0)      new_v = r & mask;
      else if (kind == 1) new_v = old_v | (r & mask);
      else                new_v = old_v & ~r & mask;
      e.val = 32'(old_v);
      case (grp)
        0: m_vstart[k] = int'(new_v);
        1: m_vxsat[k] = int'(new_v);
        2: m_vxrm[k] = int'(new_v);
        default: begin m_vxrm[k] = int'(new_v >> 1); m_vxsat[k] = int'(new_v & 1); end
      endcase
    end
    if (late_set && !(op >= 7 && op <= 9) && !(op >= 13)) m_vxsat[k] = 1;
    e.vtype = vtype_of(k);
    e.vl = 32'(m_vl[k]);
    e.vstart = 32'(m_vstart[k]);
    e.vxrm = 32'(m_vxrm[k]);
    e.vxsat = 32'(m_vxsat[k]);
  endtask

  // monitor: while a result is presented it must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (res_valid_w[k]) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("unexpected_result", k, 32'(res_valid_w[k]), 32'd0);
          end else begin
            e = (k == 0) ? q0[0] : q1[0];
            chk("res_val", k, res_val_w[k], e.val);
            chk("res_id", k, 32'(res_id_w[k]), e.id);
            chk("vtype", k, vtype_w[k], e.vtype);
            chk("vl", k, 32'(vl_w[k]), e.vl);
            chk("vstart", k, 32'(vstart_w[k]), e.vstart);
            chk("vxrm", k, 32'(vxrm_w[k]), e.vxrm);
            chk("vxsat", k, 32'(vxsat_w[k]), e.vxsat);
            if (res_ready_i) begin
              if (k == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic issue(input int op, input int sew, input int lmul, input int agn, input bit vlm,
                       input bit keep, input logic [31:0] rs1, input int w, input int hold, input bit vset);
    exp_t e;
    int n, lat, cnt;
    bit drain;
    logic [2:0] id;
    id = 3'($urandom_range(0, 7));
    n = 0;
    while (!(op_ready_w[0] && op_ready_w[1]) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 32'(op_ready_w[0]), 32'd1);
    drain = !(op inside {1, 2, 3});
    op_csr_i = 4'(op); op_vsew_i = 2'(sew); op_lmul_i = 3'(lmul); op_agnostic_i = 2'(agn);
    op_vlmax_i = vlm; op_keep_vl_i = keep; op_rs1_i = rs1; op_id_i = id;
    op_valid_i = 1'b1;
    vec_idle_i = (w == 0);
    res_ready_i = (hold == 0);
    for (int k = 0; k < 2; k++) begin
      model_exec(k, op, sew, lmul, agn, vlm, keep, rs1, id,
                 vset && drain && w >= 1, vset && !(drain && w >= 1), e);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    vxsat_set_i = vset;
    vec_idle_i = (1 >= w);
    lat = 0;
    cnt = 1;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (res_valid_w[0]) break;
      @(posedge clk); #1;
      vxsat_set_i = 1'b0;
      vec_idle_i = (cnt + 1 >= w);
      cnt++;
    end
    chk("latency", 0, 32'(lat), drain ? 32'(w + 2) : 32'd2);
    chk("valid_both", 1, 32'(res_valid_w[1]), 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    res_ready_i = 1'b1;
    vxsat_set_i = 1'b0;
    @(posedge clk); #1;
    vec_idle_i = 1'b1;
  endtask

  task automatic pulse_vxsat();
    vxsat_set_i = 1'b1;
    @(posedge clk); #1;
    vxsat_set_i = 1'b0;
    for (int k = 0; k < 2; k++) m_vxsat[k] = 1;
  endtask

  task automatic check_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_vtype", k, vtype_w[k], 32'h8000_0000);
      chk("rst_vl", k, 32'(vl_w[k]), 32'd0);
      chk("rst_vstart", k, 32'(vstart_w[k]), 32'd0);
      chk("rst_vxrm", k, 32'(vxrm_w[k]), 32'd0);
      chk("rst_vxsat", k, 32'(vxsat_w[k]), 32'd0);
      chk("rst_ready", k, 32'(op_ready_w[k]), 32'd1);
      chk("rst_res_valid", k, 32'(res_valid_w[k]), 32'd0);
      chk("rst_res_val", k, res_val_w[k], 32'd0);
      chk("rst_res_id", k, 32'(res_id_w[k]), 32'd0);
    end
  endtask

  initial begin
    int op, w;
    logic [31:0] rs1;
    rst = 1'b1;
    op_valid_i = 0; vec_idle_i = 1; vxsat_set_i = 0; res_ready_i = 1;
    op_vlmax_i = 0; op_keep_vl_i = 0; op_id_i = 0; op_lmul_i = 0; op_csr_i = 0;
    op_vsew_i = 0; op_agnostic_i = 0; op_rs1_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2 check_reset();

    issue(0, 2, 1, 0, 0, 0, 32'd100, 0, 0, 0);        // VLMAX 8, vtype 0x11
    issue(0, 3, 0, 0, 0, 0, 32'd1, 0, 0, 0);          // SEW=64: illegal at ELEN 32
    issue(0, 0, 5, 3, 1, 0, 32'd0, 0, 0, 0);          // F8 with vlmax request
    issue(0, 2, 0, 0, 0, 1, 32'd0, 0, 0, 0);          // keep vl
    issue(10, 0, 0, 0, 0, 0, 32'd3, 5, 3, 0);         // vxrm write behind a 5-cycle drain
    pulse_vxsat();
    issue(15, 0, 0, 0, 0, 0, 32'd1, 0, 0, 1);         // vcsr clear; same-cycle set dropped
    issue(11, 0, 0, 0, 0, 0, 32'd0, 3, 0, 1);         // set arriving during WAIT sticks
    issue(8, 0, 0, 0, 0, 0, 32'd0, 0, 1, 0);
    issue(3, 0, 0, 0, 0, 0, 32'd0, 3, 0, 0);
    issue(4, 0, 0, 0, 0, 0, 32'hFFFF, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 32'd0, 2, 0, 0);
    issue(0, 0, 3, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);  // large AVL saturates to 128
    issue(2, 0, 0, 0, 0, 0, 32'd0, 0, 2, 0);
    issue(0, 1, 4, 0, 0, 0, 32'd5, 0, 0, 0);          // reserved lmul

    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 15);
      if ($urandom_range(0, 2) == 0) op = 0;
      rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
      w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      if ($urandom_range(0, 9) == 0) pulse_vxsat();
      issue(op, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), rs1, w,
            $urandom_range(0, 2), ($urandom_range(0, 4) == 0));
    end

    // reset while an op waits for drain: nothing may come out afterwards
    op_csr_i = 4'd13; op_rs1_i = 32'd6; op_valid_i = 1'b1; vec_idle_i = 1'b0;
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2 check_reset();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    vec_idle_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("no_result_after_rst", 0, 32'(res_valid_w[0] | res_valid_w[1]), 32'd0);
    end
    issue(14, 0, 0, 0, 0, 0, 32'd7, 0, 0, 0);         // vcsr set from clean state returns 0

    repeat (3) @(posedge clk);
    chk("sb_drain", 0, 32'(q0.size()), 32'd0);
    chk("sb_drain", 1, 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end
endmodule
